seq_pattern_tx: RTL and testbench

Moore-style serial pattern transmitter. It is the generating end of the serial bit-sequence path that our sequence detectors consume. On a start request it captures a WIDTH-bit pattern, then shifts it out MSB-first on a single-bit line. It can repeat the pattern a programmable number of times, with optional idle gap bits between repetitions, and pulses done at the end. It serves as an on-chip stimulus source for detector blocks and as a framed serial transmitter.

---
 rtl/seq_pattern_tx.sv | 136 +++++++++++++
 tb/tb_seq_pattern_tx.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: captures a WIDTH-bit pattern on start and shifts it
// out MSB-first, repeated repeat_cnt times with optional FILL gaps, then pulses done.
module seq_pattern_tx #(
  parameter int   WIDTH = 4,
  parameter int   CNT_W = 8,
  parameter int   GAP_W = 4,
  parameter logic FILL  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_cnt,
  input  logic [GAP_W-1:0] gap,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state_q,   state_d;
  logic [IDX_W-1:0] idx_q,     idx_d;
  logic [WIDTH-1:0] pattern_q, pattern_d;
  logic [CNT_W-1:0] rep_q,     rep_d;
  logic [GAP_W-1:0] gap_q,     gap_d;
  logic [GAP_W-1:0] gcnt_q,    gcnt_d;

  // Next-state and datapath update
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pattern_d = pattern_q;
    rep_d     = rep_q;
    gap_d     = gap_q;
    gcnt_d    = gcnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          pattern_d = pattern;
          rep_d     = repeat_cnt;
          gap_d     = gap;
          idx_d     = IDX_TOP;
          if (repeat_cnt == {CNT_W{1'b0}}) begin
            state_d = S_DONE;
          end else begin
            state_d = S_SEND;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SEND: begin
        if (idx_q == {IDX_W{1'b0}}) begin
          rep_d = rep_q - CNT_W'(1);
          // rep_q counts remaining passes, so the last pass ends with rep_q at one
          if (rep_q == CNT_W'(1)) begin
            state_d = S_DONE;
          end else if (gap_q == {GAP_W{1'b0}}) begin
            idx_d = IDX_TOP;
          end else begin
            state_d = S_GAP;
            gcnt_d  = gap_q;
          end
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end
      S_GAP: begin
        if (gcnt_q == GAP_W'(1)) begin
          state_d = S_SEND;
          idx_d   = IDX_TOP;
        end else begin
          gcnt_d = gcnt_q - GAP_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= {IDX_W{1'b0}};
      pattern_q <= {WIDTH{1'b0}};
      rep_q     <= {CNT_W{1'b0}};
      gap_q     <= {GAP_W{1'b0}};
      gcnt_q    <= {GAP_W{1'b0}};
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pattern_q <= pattern_d;
      rep_q     <= rep_d;
      gap_q     <= gap_d;
      gcnt_q    <= gcnt_d;
    end
  end

  // Moore output decode from registered state only
  always_comb begin
    out       = FILL;
    out_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      S_SEND: begin
        out       = pattern_q[idx_q];
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      S_GAP: begin
        busy = 1'b1;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        out = FILL;
      end
    endcase
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Scoreboard bench for seq_pattern_tx: the driver pushes the expected per-cycle
// output trace at each accepted start, and a monitor pops and compares every cycle.
module tb_seq_pattern_tx;

  localparam logic FILL_V = 1'b0;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] pattern;
  logic [7:0] repeat_cnt;
  logic [3:0] gap;
  logic       out, out_valid, busy, done;

  int checks   = 0;
  int failures = 0;
  bit mon_en   = 1'b0;

  // record layout: {out, out_valid, busy, done}
  logic [3:0] exp_q[$];

  seq_pattern_tx #(.WIDTH(4), .CNT_W(8), .GAP_W(4), .FILL(FILL_V)) dut (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern),
    .repeat_cnt(repeat_cnt), .gap(gap), .out(out), .out_valid(out_valid),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected trace of one transfer, derived from the repeat/gap rules
  task automatic push_xfer(input logic [3:0] p, input int r, input int g);
    for (int k = 0; k < r; k++) begin
      for (int b = 3; b >= 0; b--) exp_q.push_back({p[b], 1'b1, 1'b1, 1'b0});
      if (k < r - 1)
        for (int j = 0; j < g; j++) exp_q.push_back({FILL_V, 1'b0, 1'b1, 1'b0});
    end
    exp_q.push_back({FILL_V, 1'b0, 1'b0, 1'b1});
  endtask

  task automatic scramble_inputs();
    pattern    = 4'($urandom);
    repeat_cnt = 8'($urandom);
    gap        = 4'($urandom);
  endtask

  task automatic start_xfer(input logic [3:0] p, input int r, input int g);
    @(posedge clk); #1;
    start = 1'b1; pattern = p; repeat_cnt = 8'(r); gap = 4'(g);
    @(posedge clk);
    push_xfer(p, r, g);
    #1 start = 1'b0;
    scramble_inputs();
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout remaining=%0d required=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor: compare each cycle against the scoreboard or the idle value
  always @(negedge clk) begin
    if (mon_en) begin
      logic [3:0] got;
      logic [3:0] e;
      got = {out, out_valid, busy, done};
      checks++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (got !== e) begin
          failures++;
          $display("FAIL trace t=%0t got{out,vld,busy,done}=%b required=%b", $time, got, e);
        end
      end else if (got !== {FILL_V, 3'b000}) begin
        failures++;
        $display("FAIL idle t=%0t got{out,vld,busy,done}=%b required=%b", $time, got, {FILL_V, 3'b000});
      end
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; pattern = 4'd0; repeat_cnt = 8'd0; gap = 4'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;
    repeat (2) @(posedge clk);

    // single pass, back-to-back reps, gapped reps, zero reps
    start_xfer(4'b1011, 1, 0); wait_drain(50);
    start_xfer(4'b1011, 3, 0); wait_drain(50);
    start_xfer(4'b1011, 2, 2); wait_drain(50);
    start_xfer(4'b0110, 0, 5); wait_drain(50);

    // start and pattern change during the 2nd bit are ignored
    @(posedge clk); #1;
    start = 1'b1; pattern = 4'b1011; repeat_cnt = 8'd1; gap = 4'd0;
    @(posedge clk);
    push_xfer(4'b1011, 1, 0);
    #1 start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; pattern = 4'b0000;
    @(posedge clk); #1 start = 1'b0;
    wait_drain(50);

    // reset during the 3rd bit aborts with no done pulse
    @(posedge clk); #1;
    start = 1'b1; pattern = 4'b1101; repeat_cnt = 8'd2; gap = 4'd1;
    @(posedge clk);
    push_xfer(4'b1101, 2, 1);
    #1 start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    exp_q.delete();
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);

    // start held through DONE: one idle cycle, then the next transfer
    @(posedge clk); #1;
    start = 1'b1; pattern = 4'b1001; repeat_cnt = 8'd2; gap = 4'd1;
    @(posedge clk);
    push_xfer(4'b1001, 2, 1);
    exp_q.push_back({FILL_V, 3'b000});
    push_xfer(4'b0111, 1, 0);
    #1 pattern = 4'b0111; repeat_cnt = 8'd1; gap = 4'd0;
    repeat (11) @(posedge clk);
    #1 start = 1'b0;
    scramble_inputs();
    wait_drain(50);

    // maximum repeat count must not wrap
    start_xfer(4'b1110, 255, 1); wait_drain(2000);

    for (int i = 0; i < 25; i++) begin
      logic [3:0] p;
      int r, g;
      p = 4'($urandom);
      r = int'($urandom_range(0, 5));
      g = int'($urandom_range(0, 3));
      start_xfer(p, r, g);
      wait_drain(200);
      if ($urandom_range(0, 1) == 1) @(posedge clk);
    end

    repeat (3) @(posedge clk);
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout t=%0t required=finish", $time);
    $fatal(1, "timeout");
  end

endmodule
